spike_event_logger: RTL and testbench
=====================================

// Module: spike_event_logger
// PURPOSE
//  Downstream consumer of the EIF neuron spike output. Timestamps every detected spike,
//  measures the inter-spike interval (ISI), and buffers events in a small FIFO.
//  Events leave on a valid/ready stream toward the readout/host interface.
//  Drops under back-pressure are counted and flagged, so rate statistics stay honest.
// PARAMETERS
//  TS_W      16  width of timestamp and ISI fields
//  DEPTH     8   FIFO entries; power of two, >= 2
//  EDGE_MODE 0   0: every clk with spike_in=1 is an event; 1: rising edge of spike_in only
// PORTS
//  clk          in   1       clock; all logic on posedge
//  rst          in   1       asynchronous, active-high reset
//  enable       in   1       1: detect events and advance time; 0: freeze counters, ignore spikes
//  spike_in     in   1       spike from neuron (level)
//  state_in     in   8       neuron membrane state, sampled with each event
//  ev_valid     out  1       head-of-FIFO event available
//  ev_ready     in   1       consumer accepts head when ev_valid & ev_ready
//  ev_ts        out  TS_W    timestamp of event (timestamp counter value in detect cycle)
//  ev_isi       out  TS_W    cycles since previous detected spike; saturates at all-ones
//  ev_state     out  8       state_in sampled in detect cycle
//  ev_first     out  1       1: first event since reset (ev_isi forced to 0)
//  ev_gap       out  1       1: at least one event dropped immediately before this one
//  fifo_level   out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
//  drop_cnt     out  8       dropped-event count, saturates at 255
// BEHAVIOUR
//  Reset: ts counter=0, isi counter=0, first_pending=1, gap_pending=0, FIFO empty,
//   ev_valid=0, fifo_level=0, drop_cnt=0, all ev_* data outputs=0, EDGE_MODE prev-spike reg=0.
//  Timestamp counter: +1 per clk while enable=1; wraps mod 2^TS_W; holds while enable=0.
//  Detect (enable=1): EDGE_MODE=0 -> det=spike_in; EDGE_MODE=1 -> det=spike_in & ~spike_d,
//   spike_d registered every clk (including while enable=0).
//  ISI counter: cleared to 1 on det; else +1 while enable=1, saturating at 2^TS_W-1.
//   Event ISI = isi counter value in detect cycle (back-to-back spikes -> ISI=1).
//  Event word {ts, isi, state, first, gap}. first=first_pending; first=1 forces isi=0.
//   first_pending clears on the first det, whether pushed or dropped.
//  Push: on det if FIFO not full, OR full with pop in the same cycle (slot freed).
//  Drop: det while full and no pop -> event lost, drop_cnt +1 (sat 255), gap_pending=1.
//   ISI reference still advances on dropped events (ISI is between detected spikes).
//  gap field = gap_pending at push; gap_pending clears on that push.
//  Output: show-ahead FIFO; ev_* = head entry. ev_valid = ~empty.
//   Latency: event detected at edge N is visible at ev_valid after edge N+1.
//  Pop on ev_valid & ev_ready. ev_* stable while ev_valid=1 & ev_ready=0.
//   ev_ready ignored when ev_valid=0. ev_* hold last popped value when empty.
//  Simultaneous push+pop when empty: push only, since pop requires ev_valid.
//  Simultaneous push+pop otherwise: level unchanged.
//  Read/write pointers are $clog2(DEPTH)+1 bits, wrap naturally; full = MSBs differ, low bits equal.
//  enable=0 mid-stream: FIFO keeps draining; no new events; ts/isi frozen (not cleared).
//  Async rst mid-operation: FIFO contents discarded, all state to reset values immediately.
// TESTING
//  1 Reset release, enable=1, spike_in pulses at ts=5 and ts=12, ev_ready=1 ->
//    events {ts=5,isi=0,first=1} then {ts=12,isi=7,first=0}; each ev_valid 1 clk after detect.
//  2 EDGE_MODE=0, spike_in high 3 clks from ts=20 ->
//    3 events, ts 20/21/22, isi 1 on 2nd and 3rd; EDGE_MODE=1, same stimulus -> 1 event ts=20.
//  3 ev_ready=0, 10 spikes -> level 8, drop_cnt=2; ev_ready=1 then one spike ->
//    8 events drain in order, 9th has gap=1, its isi measured from 10th detected spike.
//  4 FIFO full, det with ev_ready=1 same cycle -> push accepted, level stays 8, drop_cnt unchanged.
//  5 No spikes for 70000 clks (TS_W=16), then spike -> isi=65535 (saturated), ts wrapped correctly.
//  6 rst asserted mid-drain with level=5 -> ev_valid=0, level=0, drop_cnt=0 immediately;
//    next event has first=1.

Source files
------------

// File: rtl/spike_event_logger.sv
// Spike event logger: timestamps detected spikes, measures inter-spike interval,
// and queues event words in a show-ahead FIFO with drop accounting.
module spike_event_logger #(
    parameter int TS_W      = 16,
    parameter int DEPTH     = 8,
    parameter int EDGE_MODE = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     spike_in,
    input  logic [7:0]               state_in,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic [TS_W-1:0]          ev_ts,
    output logic [TS_W-1:0]          ev_isi,
    output logic [7:0]               ev_state,
    output logic                     ev_first,
    output logic                     ev_gap,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [7:0]               drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = 2 * TS_W + 10;

    logic [EW-1:0]   mem [DEPTH];
    logic [EW-1:0]   head;
    logic [EW-1:0]   head_next;
    logic [EW-1:0]   new_word;
    logic [TS_W-1:0] ts_cnt;
    logic [TS_W-1:0] isi_cnt;
    logic            first_pending;
    logic            gap_pending;
    logic            spike_d;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_next;
    logic [PW-1:0]   rd_next;
    logic [PW-1:0]   level_after_pop;
    logic            det;
    logic            full;
    logic            pop;
    logic            push;
    logic            drop_ev;

    // Event detection, FIFO control and next head-of-queue selection
    always_comb begin
        det = 1'b0;
        if (enable) begin
            if (EDGE_MODE == 1) begin
                det = spike_in & ~spike_d;
            end else begin
                det = spike_in;
            end
        end else begin
            det = 1'b0;
        end

        full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop     = ev_valid & ev_ready;
        push    = det & (~full | pop);
        drop_ev = det & full & ~pop;

        new_word = {ts_cnt,
                    first_pending ? {TS_W{1'b0}} : isi_cnt,
                    state_in, first_pending, gap_pending};

        wr_next         = wr_ptr + PW'(push);
        rd_next         = rd_ptr + PW'(pop);
        level_after_pop = (wr_ptr - rd_ptr) - PW'(pop);

        // A word written into an otherwise empty queue bypasses the array read
        head_next = head;
        if (wr_next == rd_next) begin
            head_next = head;
        end else if (level_after_pop == {PW{1'b0}}) begin
            head_next = new_word;
        end else begin
            head_next = mem[rd_next[AW-1:0]];
        end
    end

    // Timestamp, ISI and pending-flag state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_cnt        <= {TS_W{1'b0}};
            isi_cnt       <= {TS_W{1'b0}};
            first_pending <= 1'b1;
            gap_pending   <= 1'b0;
            spike_d       <= 1'b0;
            drop_cnt      <= 8'd0;
        end else begin
            spike_d <= spike_in;
            if (enable) begin
                ts_cnt <= ts_cnt + TS_W'(1);
            end
            if (det) begin
                isi_cnt       <= TS_W'(1);
                first_pending <= 1'b0;
            end else if (enable && (isi_cnt != {TS_W{1'b1}})) begin
                isi_cnt <= isi_cnt + TS_W'(1);
            end
            if (drop_ev) begin
                gap_pending <= 1'b1;
                if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end else if (push) begin
                gap_pending <= 1'b0;
            end
        end
    end

    // FIFO pointers and registered head-of-queue outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= {PW{1'b0}};
            rd_ptr   <= {PW{1'b0}};
            head     <= {EW{1'b0}};
            ev_valid <= 1'b0;
        end else begin
            wr_ptr   <= wr_next;
            rd_ptr   <= rd_next;
            head     <= head_next;
            ev_valid <= (wr_next != rd_next);
        end
    end

    // Event storage array
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= {EW{1'b0}};
            end
        end else if (push) begin
            mem[wr_ptr[AW-1:0]] <= new_word;
        end
    end

    assign fifo_level = wr_ptr - rd_ptr;
    assign ev_ts      = head[EW-1 -: TS_W];
    assign ev_isi     = head[EW-1-TS_W -: TS_W];
    assign ev_state   = head[9:2];
    assign ev_first   = head[1];
    assign ev_gap     = head[0];

endmodule

// File: tb/tb_spike_event_logger.sv
// Directed bench for spike_event_logger: a level-mode and an edge-mode instance
// share one stimulus stream; expected values are hand-derived cycle counts.
module tb_spike_event_logger;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        spike_in;
    logic [7:0]  state_in;
    logic        ev_ready;

    logic        v0, f0, g0, v1, f1, g1;
    logic [15:0] ts0, isi0, ts1, isi1;
    logic [7:0]  st0, st1, dc0, dc1;
    logic [3:0]  lv0, lv1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    spike_event_logger #(.TS_W(16), .DEPTH(8), .EDGE_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .spike_in(spike_in), .state_in(state_in),
        .ev_valid(v0), .ev_ready(ev_ready), .ev_ts(ts0), .ev_isi(isi0), .ev_state(st0),
        .ev_first(f0), .ev_gap(g0), .fifo_level(lv0), .drop_cnt(dc0)
    );

    spike_event_logger #(.TS_W(16), .DEPTH(8), .EDGE_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .spike_in(spike_in), .state_in(state_in),
        .ev_valid(v1), .ev_ready(ev_ready), .ev_ts(ts1), .ev_isi(isi1), .ev_state(st1),
        .ev_first(f1), .ev_gap(g1), .fifo_level(lv1), .drop_cnt(dc1)
    );

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst      = 1'b1;
        enable   = 1'b1;
        spike_in = 1'b0;
        state_in = 8'h00;
        ev_ready = 1'b1;
        tick(2);
        chk("rst_valid", 32'(v0), 32'd0);
        chk("rst_level", 32'(lv0), 32'd0);
        chk("rst_drop", 32'(dc0), 32'd0);
        chk("rst_ts", 32'(ts0), 32'd0);
        chk("rst_first", 32'(f0), 32'd0);
        rst = 1'b0;

        // Test 1: spikes at ts=5 and ts=12
        tick(5);
        spike_in = 1'b1; state_in = 8'hA5;
        tick(1);
        spike_in = 1'b0;
        chk("t1_v_a", 32'(v0), 32'd1);
        chk("t1_ts_a", 32'(ts0), 32'd5);
        chk("t1_isi_a", 32'(isi0), 32'd0);
        chk("t1_first_a", 32'(f0), 32'd1);
        chk("t1_state_a", 32'(st0), 32'hA5);
        chk("t1_level_a", 32'(lv0), 32'd1);
        tick(1);
        chk("t1_popped", 32'(v0), 32'd0);
        tick(5);
        spike_in = 1'b1; state_in = 8'h3C;
        tick(1);
        spike_in = 1'b0;
        chk("t1_v_b", 32'(v0), 32'd1);
        chk("t1_ts_b", 32'(ts0), 32'd12);
        chk("t1_isi_b", 32'(isi0), 32'd7);
        chk("t1_first_b", 32'(f0), 32'd0);
        chk("t1_m1_ts_b", 32'(ts1), 32'd12);

        // Test 2: spike_in held high three cycles from ts=20
        tick(7);
        spike_in = 1'b1;
        tick(1);
        chk("t2_ts_a", 32'(ts0), 32'd20);
        chk("t2_isi_a", 32'(isi0), 32'd8);
        chk("t2_m1_v_a", 32'(v1), 32'd1);
        chk("t2_m1_ts_a", 32'(ts1), 32'd20);
        tick(1);
        chk("t2_ts_b", 32'(ts0), 32'd21);
        chk("t2_isi_b", 32'(isi0), 32'd1);
        chk("t2_m1_v_b", 32'(v1), 32'd0);
        tick(1);
        spike_in = 1'b0;
        ev_ready = 1'b0;
        chk("t2_ts_c", 32'(ts0), 32'd22);
        chk("t2_isi_c", 32'(isi0), 32'd1);
        chk("t2_m1_v_c", 32'(v1), 32'd0);

        // Test 3: overflow with ev_ready=0, spikes at ts=25..34
        tick(1);
        ev_ready = 1'b1;
        tick(1);
        ev_ready = 1'b0;
        chk("t3_empty", 32'(v0), 32'd0);
        spike_in = 1'b1;
        tick(10);
        spike_in = 1'b0;
        chk("t3_level", 32'(lv0), 32'd8);
        chk("t3_drop", 32'(dc0), 32'd2);
        chk("t3_head_isi", 32'(isi0), 32'd3);
        chk("t3_head_gap", 32'(g0), 32'd0);
        ev_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("t3_drain_v", 32'(v0), 32'd1);
            chk("t3_drain_ts", 32'(ts0), 32'(25 + i));
            tick(1);
        end
        chk("t3_drained", 32'(v0), 32'd0);
        spike_in = 1'b1;
        tick(1);
        spike_in = 1'b0;
        chk("t3_gap_ts", 32'(ts0), 32'd43);
        chk("t3_gap", 32'(g0), 32'd1);
        chk("t3_gap_isi", 32'(isi0), 32'd9);
        chk("t3_drop_hold", 32'(dc0), 32'd2);

        // Test 4: push while full with a pop in the same cycle
        tick(1);
        ev_ready = 1'b0;
        spike_in = 1'b1;
        tick(8);
        chk("t4_full", 32'(lv0), 32'd8);
        chk("t4_gapclr", 32'(g0), 32'd0);
        ev_ready = 1'b1;
        tick(1);
        spike_in = 1'b0;
        ev_ready = 1'b0;
        chk("t4_level", 32'(lv0), 32'd8);
        chk("t4_drop", 32'(dc0), 32'd2);
        chk("t4_head", 32'(ts0), 32'd46);
        tick(2);
        chk("t4_stall_ts", 32'(ts0), 32'd46);
        chk("t4_stall_lv", 32'(lv0), 32'd8);

        // Test 6: asynchronous reset in the middle of a drain
        ev_ready = 1'b1;
        tick(3);
        chk("t6_level5", 32'(lv0), 32'd5);
        chk("t6_head", 32'(ts0), 32'd49);
        rst = 1'b1;
        #1;
        chk("t6_valid", 32'(v0), 32'd0);
        chk("t6_level", 32'(lv0), 32'd0);
        chk("t6_drop", 32'(dc0), 32'd0);
        tick(1);
        rst = 1'b0;
        tick(3);
        spike_in = 1'b1;
        tick(1);
        spike_in = 1'b0;
        chk("t6_ts", 32'(ts0), 32'd3);
        chk("t6_first", 32'(f0), 32'd1);
        chk("t6_isi", 32'(isi0), 32'd0);
        tick(1);

        // enable=0: spikes ignored, counters frozen at ts=5
        enable   = 1'b0;
        spike_in = 1'b1;
        tick(10);
        chk("dis_valid", 32'(v0), 32'd0);
        chk("dis_level", 32'(lv0), 32'd0);
        enable   = 1'b1;
        spike_in = 1'b0;

        // Test 5: 70000 idle cycles, then a spike at ts=(5+70000) mod 65536
        tick(70000);
        spike_in = 1'b1;
        tick(1);
        spike_in = 1'b0;
        chk("t5_ts", 32'(ts0), 32'd4469);
        chk("t5_isi", 32'(isi0), 32'd65535);
        chk("t5_first", 32'(f0), 32'd0);
        tick(1);
        chk("t5_popped", 32'(v0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
